gf_arith_unit: RTL and testbench

Parametrised GF(p) arithmetic unit for the ECC point-arithmetic datapath. It performs modular add, sub, mult and div on WIDTH-bit operands. Mult uses interleaved shift-add reduction; div computes in_0·in_1⁻¹ mod p by the binary extended-Euclid method. The control FSM drives it through a start/ready/done handshake. Results and per-op done pulses feed the point add/double controller.

---
 rtl/gf_pkg.sv | 20 ++
 rtl/gf_mod_addsub.sv | 36 +++
 rtl/gf_arith_unit.sv | 250 +++++++++++++++++++++++++
 tb/tb_gf_arith_unit.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// gf_pkg: shared encodings for the GF(p) arithmetic unit.
//   gf_op_e    : operation_select encodings (add, sub, mult, div)
//   gf_state_e : control FSM states
package gf_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } gf_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } gf_state_e;

endpackage

// File: rtl/gf_mod_addsub.sv
// gf_mod_addsub: combinational modular helpers, all reduced mod p.
//   x, y : operands, assumed < p
//   p    : odd modulus
//   sum  : (x + y) mod p, computed with a WIDTH+1 bit intermediate
//   diff : (x - y) mod p, p added back on borrow
//   half : x / 2 mod p, i.e. x >> 1 for even x, (x + p) >> 1 for odd x
module gf_mod_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] half
);

  logic [WIDTH:0]   s_raw;
  logic [WIDTH:0]   d_raw;
  logic             s_ge_p;
  logic [WIDTH-1:0] p_half_up;

  assign s_raw  = {1'b0, x} + {1'b0, y};
  assign s_ge_p = (s_raw >= {1'b0, p});
  // s - p < p, so the subtraction is exact in WIDTH bits.
  assign sum    = s_ge_p ? (s_raw[WIDTH-1:0] - p) : s_raw[WIDTH-1:0];

  assign d_raw  = {1'b0, x} - {1'b0, y};
  assign diff   = d_raw[WIDTH] ? (d_raw[WIDTH-1:0] + p) : d_raw[WIDTH-1:0];

  // For odd x and odd p: (x + p) >> 1 == (x >> 1) + (p >> 1) + 1, which
  // stays below p and so never needs the WIDTH+1 bit intermediate.
  assign p_half_up = (p >> 1) + WIDTH'(1);
  assign half      = (x >> 1) + (x[0] ? p_half_up : '0);

endmodule

// File: rtl/gf_arith_unit.sv
// gf_arith_unit: GF(p) add / sub / mult / div with start-ready-done handshake.
//   i_clk, i_rst       : clock, asynchronous active-low reset
//   i_start            : op request, taken when o_ready = 1
//   operation_select   : 00 add, 01 sub, 10 mult, 11 div (sampled with i_start)
//   in_0, in_1, prime  : operands a, b and odd prime p (sampled with i_start)
//   o_ready            : high in IDLE and DONE
//   result             : last completed result, held until the next completion
//   o_done, done_*     : one-cycle completion pulse plus per-op identifier
//   o_err              : valid with o_done, 1 = division by zero (or step limit)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for i_start
// MUL   | one multiplier bit per cycle, MSB first, WIDTH cycles
// DIV   | one binary extended-Euclid step per cycle until u==1 or v==1
// DONE  | result valid, o_done pulses; accepts a back-to-back i_start
module gf_arith_unit
  import gf_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       operation_select,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] prime,
  output logic             o_ready,
  output logic [WIDTH-1:0] result,
  output logic             o_done,
  output logic             done_add,
  output logic             done_sub,
  output logic             done_mult,
  output logic             done_div,
  output logic             o_err
);

  localparam int CNT_W = $clog2(2*WIDTH+2);

  gf_state_e        state, state_next;
  gf_op_e           op_q, op_in;
  logic             accept;

  logic [WIDTH-1:0] a_q, b_q, p_q, r_q;
  logic [WIDTH-1:0] u_q, v_q, x1_q, x2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             err_q;

  logic [WIDTH-1:0] ux, uy, up;
  logic [WIDTH-1:0] sum0, diff0, half0;
  logic [WIDTH-1:0] sum1, unused_diff1, unused_half1;
  logic [WIDTH-1:0] r_next;

  logic             u_ge_v, div_sel_x1;
  logic [WIDTH-1:0] u_n, v_n, x1_n, x2_n;
  logic             u_one, v_one;
  logic             cnt_zero;

  assign op_in    = gf_op_e'(operation_select);
  assign accept   = i_start && o_ready;
  assign cnt_zero = (cnt_q == '0);

  // Shared modular unit: raw inputs for add/sub, 2r for mult, and the
  // halve / subtract of the selected x register for div.
  assign u_ge_v     = (u_q >= v_q);
  assign div_sel_x1 = !u_q[0] || (v_q[0] && u_ge_v);

  always_comb begin
    ux = in_0;
    uy = in_1;
    up = prime;
    case (state)
      MUL: begin
        ux = r_q;
        uy = r_q;
        up = p_q;
      end
      DIV: begin
        ux = div_sel_x1 ? x1_q : x2_q;
        uy = div_sel_x1 ? x2_q : x1_q;
        up = p_q;
      end
      default: ;
    endcase
  end

  gf_mod_addsub #(.WIDTH(WIDTH)) u_addsub0 (
    .x    (ux),
    .y    (uy),
    .p    (up),
    .sum  (sum0),
    .diff (diff0),
    .half (half0)
  );

  // Second adder chains after the doubling so a mult bit takes one cycle.
  gf_mod_addsub #(.WIDTH(WIDTH)) u_addsub1 (
    .x    (sum0),
    .y    (a_q),
    .p    (p_q),
    .sum  (sum1),
    .diff (unused_diff1),
    .half (unused_half1)
  );

  // b is shifted left each iteration so its MSB is always the current bit.
  assign r_next = b_q[WIDTH-1] ? sum1 : sum0;

  always_comb begin
    u_n  = u_q;
    v_n  = v_q;
    x1_n = x1_q;
    x2_n = x2_q;
    if (!u_q[0]) begin
      u_n  = u_q >> 1;
      x1_n = half0;
    end else if (!v_q[0]) begin
      v_n  = v_q >> 1;
      x2_n = half0;
    end else if (u_ge_v) begin
      u_n  = u_q - v_q;
      x1_n = diff0;
    end else begin
      v_n  = v_q - u_q;
      x2_n = diff0;
    end
  end

  assign u_one = (u_n == WIDTH'(1));
  assign v_one = (v_n == WIDTH'(1));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    o_ready    = 1'b0;
    o_done     = 1'b0;
    done_add   = 1'b0;
    done_sub   = 1'b0;
    done_mult  = 1'b0;
    done_div   = 1'b0;
    case (state)
      IDLE, DONE: begin
        o_ready = 1'b1;
        if (state == DONE) begin
          o_done    = 1'b1;
          done_add  = (op_q == OP_ADD);
          done_sub  = (op_q == OP_SUB);
          done_mult = (op_q == OP_MUL);
          done_div  = (op_q == OP_DIV);
        end
        if (i_start) begin
          case (op_in)
            OP_MUL:  state_next = MUL;
            // b of 0 or 1 needs no Euclid steps.
            OP_DIV:  state_next = (in_1 == '0 || in_1 == WIDTH'(1)) ? DONE : DIV;
            default: state_next = DONE;
          endcase
        end else begin
          state_next = IDLE;
        end
      end
      MUL: if (cnt_zero) state_next = DONE;
      DIV: if (u_one || v_one || cnt_zero) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      r_q      <= '0;
      u_q      <= '0;
      v_q      <= '0;
      x1_q     <= '0;
      x2_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      op_q <= op_in;
      a_q  <= in_0;
      b_q  <= in_1;
      p_q  <= prime;
      r_q  <= '0;
      case (op_in)
        OP_ADD: begin
          result_q <= sum0;
          err_q    <= 1'b0;
        end
        OP_SUB: begin
          result_q <= diff0;
          err_q    <= 1'b0;
        end
        OP_MUL: cnt_q <= CNT_W'(WIDTH-1);
        default: begin
          u_q   <= in_1;
          v_q   <= prime;
          x1_q  <= in_0;
          x2_q  <= '0;
          cnt_q <= CNT_W'(2*WIDTH);
          if (in_1 == '0) begin
            result_q <= '0;
            err_q    <= 1'b1;
          end else if (in_1 == WIDTH'(1)) begin
            result_q <= in_0;
            err_q    <= 1'b0;
          end
        end
      endcase
    end else if (state == MUL) begin
      r_q   <= r_next;
      b_q   <= b_q << 1;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_zero) begin
        result_q <= r_next;
        err_q    <= 1'b0;
      end
    end else if (state == DIV) begin
      u_q   <= u_n;
      v_q   <= v_n;
      x1_q  <= x1_n;
      x2_q  <= x2_n;
      cnt_q <= cnt_q - CNT_W'(1);
      if (u_one) begin
        result_q <= x1_n;
        err_q    <= 1'b0;
      end else if (v_one) begin
        result_q <= x2_n;
        err_q    <= 1'b0;
      end else if (cnt_zero) begin
        // Step budget exhausted: only reachable with out-of-range operands.
        result_q <= '0;
        err_q    <= 1'b1;
      end
    end
  end

  assign result = result_q;
  assign o_err  = err_q;

endmodule

// File: tb/tb_gf_arith_unit.sv
module tb_gf_arith_unit;

  localparam logic [31:0] P32 = 32'hFFFF_FFFB;

  logic clk = 1'b0;
  logic rst_n;

  logic       st8;
  logic [1:0] op8;
  logic [7:0] a8, b8, p8, res8;
  logic       rdy8, dn8, da8, ds8, dm8, dd8, er8;

  logic        st32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, p32, res32;
  logic        rdy32, dn32, da32, ds32, dm32, dd32, er32;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gf_arith_unit #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst_n), .i_start(st8), .operation_select(op8),
    .in_0(a8), .in_1(b8), .prime(p8), .o_ready(rdy8), .result(res8),
    .o_done(dn8), .done_add(da8), .done_sub(ds8), .done_mult(dm8),
    .done_div(dd8), .o_err(er8)
  );

  gf_arith_unit #(.WIDTH(32)) dut32 (
    .i_clk(clk), .i_rst(rst_n), .i_start(st32), .operation_select(op32),
    .in_0(a32), .in_1(b32), .prime(p32), .o_ready(rdy32), .result(res32),
    .o_done(dn32), .done_add(da32), .done_sub(ds32), .done_mult(dm32),
    .done_div(dd32), .o_err(er32)
  );

  // ---------------- reference model: plain modular arithmetic ----------------
  function automatic logic [63:0] powmod(input logic [63:0] base, input logic [63:0] e,
                                         input logic [63:0] m);
    logic [63:0] acc = 64'd1;
    logic [63:0] bb  = base % m;
    logic [63:0] ee  = e;
    while (ee != 0) begin
      if (ee[0]) acc = (acc * bb) % m;
      bb = (bb * bb) % m;
      ee = ee >> 1;
    end
    return acc;
  endfunction

  function automatic logic [63:0] ref_calc(input logic [1:0] op, input logic [63:0] a,
                                           input logic [63:0] b, input logic [63:0] p);
    case (op)
      2'd0:    return (a + b) % p;
      2'd1:    return (a + p - b) % p;
      2'd2:    return (a * b) % p;
      default: return (b == 0) ? 64'd0 : (a * powmod(b, p - 2, p)) % p;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input int w);
    return (op == 2'd2) ? w + 1 : 1;
  endfunction

  // ---------------- drivers (no checking inside) ----------------
  task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] p, output logic [7:0] res, output logic err,
                      output logic [3:0] fl, output int lat, output bit ok);
    @(negedge clk);
    op8 = op; a8 = a; b8 = b; p8 = p; st8 = 1'b1;
    ok = 1'b0; lat = 0; res = '0; err = 1'b0; fl = '0;
    while (!ok && lat < 200) begin
      @(posedge clk); #1;
      if (lat == 0) begin
        st8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); p8 = 8'($urandom); op8 = 2'($urandom);
      end
      lat++;
      if (dn8) begin
        ok = 1'b1; res = res8; err = er8; fl = {dd8, dm8, ds8, da8};
      end
    end
  endtask

  task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, output logic [31:0] res, output logic err,
                       output logic [3:0] fl, output int lat, output bit ok);
    @(negedge clk);
    op32 = op; a32 = a; b32 = b; p32 = p; st32 = 1'b1;
    ok = 1'b0; lat = 0; res = '0; err = 1'b0; fl = '0;
    while (!ok && lat < 200) begin
      @(posedge clk); #1;
      if (lat == 0) begin
        st32 = 1'b0;
        a32 = $urandom; b32 = $urandom; p32 = $urandom; op32 = 2'($urandom);
      end
      lat++;
      if (dn32) begin
        ok = 1'b1; res = res32; err = er32; fl = {dd32, dm32, ds32, da32};
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    st8 = 0; op8 = 0; a8 = 0; b8 = 0; p8 = 8'd251;
    st32 = 0; op32 = 0; a32 = 0; b32 = 0; p32 = P32;
    #12;
    tests++;
    if (res8 !== 8'd0 || er8 !== 1'b0 || rdy8 !== 1'b1 || {dn8, da8, ds8, dm8, dd8} !== 5'b0) begin
      fails++;
      $display("FAIL reset8: res=%0d err=%b rdy=%b done=%b, need res=0 err=0 rdy=1 done=00000",
               res8, er8, rdy8, {dn8, da8, ds8, dm8, dd8});
    end
    tests++;
    if (res32 !== 32'd0 || er32 !== 1'b0 || rdy32 !== 1'b1 || {dn32, da32, ds32, dm32, dd32} !== 5'b0) begin
      fails++;
      $display("FAIL reset32: res=%0d err=%b rdy=%b done=%b, need res=0 err=0 rdy=1 done=00000",
               res32, er32, rdy32, {dn32, da32, ds32, dm32, dd32});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_plan_w8();
    logic [1:0] ops [7] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [7:0] as  [7] = '{8'd200, 8'd5, 8'd17, 8'd250, 8'd1, 8'd3, 8'd250};
    logic [7:0] bs  [7] = '{8'd100, 8'd10, 8'd15, 8'd250, 8'd2, 8'd0, 8'd250};
    logic [7:0] exp [7] = '{8'd49, 8'd246, 8'd4, 8'd1, 8'd126, 8'd0, 8'd1};
    int         lats[7] = '{1, 1, 9, 9, 2, 1, -1};
    logic [7:0] res; logic err; logic [3:0] fl; int lat; bit ok;
    for (int i = 0; i < 7; i++) begin
      run8(ops[i], as[i], bs[i], 8'd251, res, err, fl, lat, ok);
      tests++;
      if (!ok || res !== exp[i] || err !== (ops[i] == 2'd3 && bs[i] == 0) ||
          fl !== (4'b0001 << ops[i])) begin
        fails++;
        $display("FAIL plan8[%0d]: done=%b res=%0d err=%b flags=%b, need res=%0d err=%b flags=%b",
                 i, ok, res, err, fl, exp[i], (ops[i] == 2'd3 && bs[i] == 0), 4'b0001 << ops[i]);
      end
      if (lats[i] > 0) begin
        tests++;
        if (lat != lats[i]) begin
          fails++;
          $display("FAIL plan8_lat[%0d]: latency %0d, need %0d", i, lat, lats[i]);
        end
      end
    end
  endtask

  task automatic test_plan_w32();
    logic [1:0]  ops [3] = '{2'd2, 2'd3, 2'd0};
    logic [31:0] as  [3] = '{P32 - 1, 32'd1, P32 - 1};
    logic [31:0] bs  [3] = '{P32 - 1, 32'd2, 32'd1};
    logic [31:0] exp [3] = '{32'd1, 32'h7FFF_FFFE, 32'd0};
    int          lats[3] = '{33, 2, 1};
    logic [31:0] res; logic err; logic [3:0] fl; int lat; bit ok;
    for (int i = 0; i < 3; i++) begin
      run32(ops[i], as[i], bs[i], P32, res, err, fl, lat, ok);
      tests++;
      if (!ok || res !== exp[i] || err !== 1'b0 || fl !== (4'b0001 << ops[i]) || lat != lats[i]) begin
        fails++;
        $display("FAIL plan32[%0d]: done=%b res=%h err=%b flags=%b lat=%0d, need res=%h err=0 flags=%b lat=%0d",
                 i, ok, res, err, fl, lat, exp[i], 4'b0001 << ops[i], lats[i]);
      end
    end
  endtask

  task automatic test_random_w8();
    logic [7:0] plist [4] = '{8'd251, 8'd241, 8'd131, 8'd13};
    logic [7:0] p, a, b, exp, res; logic [1:0] op; logic err, experr; logic [3:0] fl;
    int lat; bit ok;
    for (int i = 0; i < 40; i++) begin
      p  = plist[$urandom_range(3)];
      op = 2'($urandom_range(3));
      a  = 8'($urandom_range(32'(p) - 1));
      b  = 8'($urandom_range(32'(p) - 1));
      if (op == 2'd3 && $urandom_range(5) == 0) b = 8'd0;
      exp    = 8'(ref_calc(op, 64'(a), 64'(b), 64'(p)));
      experr = (op == 2'd3 && b == 0);
      run8(op, a, b, p, res, err, fl, lat, ok);
      tests++;
      if (!ok || res !== exp || err !== experr || fl !== (4'b0001 << op)) begin
        fails++;
        $display("FAIL rand8 op=%0d a=%0d b=%0d p=%0d: done=%b res=%0d err=%b flags=%b, need res=%0d err=%b flags=%b",
                 op, a, b, p, ok, res, err, fl, exp, experr, 4'b0001 << op);
      end
      tests++;
      if ((op != 2'd3 || b == 0) ? (lat != ref_lat(op, 8)) : (lat < 1 || lat > 17)) begin
        fails++;
        $display("FAIL rand8_lat op=%0d b=%0d: latency %0d, need %0d (div: 1..17)", op, b, lat, ref_lat(op, 8));
      end
    end
  endtask

  task automatic test_random_w32();
    logic [31:0] plist [3] = '{P32, 32'h7FFF_FFFF, 32'd1000003};
    logic [31:0] p, a, b, exp, res; logic [1:0] op; logic err, experr; logic [3:0] fl;
    int lat; bit ok;
    for (int i = 0; i < 30; i++) begin
      p  = plist[$urandom_range(2)];
      op = 2'($urandom_range(3));
      a  = $urandom_range(p - 1);
      b  = $urandom_range(p - 1);
      if (op == 2'd3 && $urandom_range(5) == 0) b = 32'd0;
      exp    = 32'(ref_calc(op, 64'(a), 64'(b), 64'(p)));
      experr = (op == 2'd3 && b == 0);
      run32(op, a, b, p, res, err, fl, lat, ok);
      tests++;
      if (!ok || res !== exp || err !== experr || fl !== (4'b0001 << op)) begin
        fails++;
        $display("FAIL rand32 op=%0d a=%h b=%h p=%h: done=%b res=%h err=%b flags=%b, need res=%h err=%b flags=%b",
                 op, a, b, p, ok, res, err, fl, exp, experr, 4'b0001 << op);
      end
      tests++;
      if ((op != 2'd3 || b == 0) ? (lat != ref_lat(op, 32)) : (lat < 1 || lat > 65)) begin
        fails++;
        $display("FAIL rand32_lat op=%0d b=%h: latency %0d, need %0d (div: 1..65)", op, b, lat, ref_lat(op, 32));
      end
    end
  endtask

  task automatic test_handshake();
    int lat = 0; bit ok = 1'b0; bit ready_bad = 1'b0;
    @(negedge clk);
    op8 = 2'd2; a8 = 8'd17; b8 = 8'd15; p8 = 8'd251; st8 = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    op8 = 2'd0; a8 = 8'd3; b8 = 8'd5;
    while (!ok && lat < 50) begin
      if (dn8) ok = 1'b1;
      else begin
        if (rdy8 !== 1'b0) ready_bad = 1'b1;
        @(posedge clk); #1;
        lat++;
      end
    end
    st8 = 1'b0;
    tests++;
    if (ready_bad) begin
      fails++;
      $display("FAIL hs_ready: o_ready was 1 during MUL, need 0");
    end
    tests++;
    if (!ok || res8 !== 8'd4 || dm8 !== 1'b1 || lat != 9) begin
      fails++;
      $display("FAIL hs_ignore: done=%b res=%0d done_mult=%b lat=%0d, need res=4 done_mult=1 lat=9",
               ok, res8, dm8, lat);
    end
    @(posedge clk); #1;
    tests++;
    if (dn8 !== 1'b0 || rdy8 !== 1'b1 || res8 !== 8'd4) begin
      fails++;
      $display("FAIL hs_after: o_done=%b ready=%b res=%0d, need o_done=0 ready=1 res=4", dn8, rdy8, res8);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] res; logic err; logic [3:0] fl; int lat; bit ok;
    run8(2'd2, 8'd250, 8'd250, 8'd251, res, err, fl, lat, ok);
    op8 = 2'd0; a8 = 8'd200; b8 = 8'd100; p8 = 8'd251; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    tests++;
    if (!ok || res !== 8'd1 || dn8 !== 1'b1 || da8 !== 1'b1 || dm8 !== 1'b0 || res8 !== 8'd49) begin
      fails++;
      $display("FAIL b2b: mult res=%0d, then o_done=%b done_add=%b done_mult=%b res=%0d, need 1 then 1 1 0 49",
               res, dn8, da8, dm8, res8);
    end
    @(posedge clk); #1;
    tests++;
    if (dn8 !== 1'b0 || da8 !== 1'b0 || res8 !== 8'd49) begin
      fails++;
      $display("FAIL b2b_pulse: o_done=%b done_add=%b res=%0d, need 0 0 49", dn8, da8, res8);
    end
  endtask

  task automatic test_reset_mid_div();
    logic [31:0] res; logic err; logic [3:0] fl; int lat; bit ok; bit spurious = 1'b0;
    run32(2'd0, 32'd5, 32'd6, P32, res, err, fl, lat, ok);
    @(negedge clk);
    op32 = 2'd3; a32 = 32'd3; b32 = 32'd7; p32 = P32; st32 = 1'b1;
    @(posedge clk); #1;
    st32 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (rdy32 !== 1'b0 || res32 !== 32'd11) begin
      fails++;
      $display("FAIL mid_div_busy: ready=%b res=%0d, need ready=0 res=11", rdy32, res32);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (res32 !== 32'd0 || rdy32 !== 1'b1 || dn32 !== 1'b0 || er32 !== 1'b0) begin
      fails++;
      $display("FAIL mid_div_reset: res=%0d ready=%b o_done=%b err=%b, need 0 1 0 0", res32, rdy32, dn32, er32);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (dn32 !== 1'b0) spurious = 1'b1;
    end
    tests++;
    if (spurious) begin
      fails++;
      $display("FAIL mid_div_nodone: o_done seen after reset release, need none");
    end
    run32(2'd0, P32 - 1, 32'd2, P32, res, err, fl, lat, ok);
    tests++;
    if (!ok || res !== 32'd1 || err !== 1'b0 || fl !== 4'b0001 || lat != 1) begin
      fails++;
      $display("FAIL mid_div_recover: done=%b res=%0d err=%b flags=%b lat=%0d, need res=1 err=0 flags=0001 lat=1",
               ok, res, err, fl, lat);
    end
  endtask

  initial begin
    test_reset();
    test_plan_w8();
    test_plan_w32();
    test_handshake();
    test_back_to_back();
    test_random_w8();
    test_random_w32();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
